iomem_gpio_bank: RTL and testbench

Parametrised memory-mapped GPIO peripheral on the PicoSoC iomem bus; successor to the fixed 16-bit LED/switch register in the top level.
- Provides configurable-width output and input ports, multi-stage input synchronisers, and per-bit rising/falling edge capture.
- Edge-capture status is write-1-to-clear and drives a level interrupt suitable for an irq_5..irq_7 input.
- Sits between picosoc_noflash iomem signals and board pins (LEDs, switches, buttons).

---
 rtl/gpio_pkg.sv | 10 +
 rtl/gpio_sync_edge.sv | 26 ++
 rtl/iomem_gpio_bank.sv | 66 ++++++
 tb/tb_iomem_gpio_bank.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// gpio_pkg: register byte offsets and bus data width shared by the GPIO bank
package gpio_pkg;
  localparam int REG_W = 32;
  localparam logic [4:0] OFS_OUT     = 5'h00;
  localparam logic [4:0] OFS_IN      = 5'h04;
  localparam logic [4:0] OFS_RISE_EN = 5'h08;
  localparam logic [4:0] OFS_FALL_EN = 5'h0C;
  localparam logic [4:0] OFS_STATUS  = 5'h10;
  localparam logic [4:0] OFS_IRQ_EN  = 5'h14;
endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: STAGES-deep input synchroniser (d in; s synced level, rise/fall one-cycle edge vectors out)
module gpio_sync_edge #(
  parameter int W      = 16,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] d,
  output logic [W-1:0] s,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);
  logic [STAGES-1:0][W-1:0] chain;
  logic [W-1:0] prev;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      chain <= '0;
      prev  <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  assign s    = chain[STAGES-1];
  assign rise = s & ~prev;
  assign fall = ~s & prev;
endmodule

// File: rtl/iomem_gpio_bank.sv
// iomem_gpio_bank: iomem-mapped GPIO (iomem_* bus, gpio_in sync+edge capture, gpio_out pins, level irq)
module iomem_gpio_bank
  import gpio_pkg::*;
#(
  parameter logic [7:0] BASE_SEL    = 8'h03,
  parameter int         N_OUT       = 16,
  parameter int         N_IN        = 16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             iomem_valid,
  output logic             iomem_ready,
  input  logic [3:0]       iomem_wstrb,
  input  logic [31:0]      iomem_addr,
  input  logic [31:0]      iomem_wdata,
  output logic [31:0]      iomem_rdata,
  input  logic [N_IN-1:0]  gpio_in,
  output logic [N_OUT-1:0] gpio_out,
  output logic             irq
);
  logic [N_OUT-1:0] out_r;
  logic [N_IN-1:0]  rise_en, fall_en, irq_en, status, s, rise, fall, clr;
  logic [REG_W-1:0] mask, wm, rd;
  logic [4:0]       ofs;
  logic             sel, wr, unused;
  gpio_sync_edge #(.W(N_IN), .STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .resetn(resetn), .d(gpio_in), .s(s), .rise(rise), .fall(fall)
  );
  // !iomem_ready gates the cycle after completion so each request yields one pulse
  assign sel    = iomem_valid && !iomem_ready && iomem_addr[31:24] == BASE_SEL;
  assign wr     = sel && |iomem_wstrb;
  assign ofs    = {iomem_addr[4:2], 2'b00};
  assign mask   = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}}, {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
  assign wm     = iomem_wdata & mask;
  assign clr    = wr && ofs == OFS_STATUS ? wm[N_IN-1:0] : '0;
  assign irq    = |(status & irq_en);
  assign unused = ^{iomem_addr[23:5], iomem_addr[1:0], mask, wm};
  assign gpio_out = out_r;
  always_comb
    rd = ofs == OFS_OUT     ? REG_W'(out_r)   :
         ofs == OFS_IN      ? REG_W'(s)       :
         ofs == OFS_RISE_EN ? REG_W'(rise_en) :
         ofs == OFS_FALL_EN ? REG_W'(fall_en) :
         ofs == OFS_STATUS  ? REG_W'(status)  :
         ofs == OFS_IRQ_EN  ? REG_W'(irq_en)  : '0;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      out_r       <= '0;
      rise_en     <= '0;
      fall_en     <= '0;
      irq_en      <= '0;
      status      <= '0;
    end else begin
      iomem_ready <= sel;
      if (sel) iomem_rdata <= rd;
      if (wr && ofs == OFS_OUT) out_r <= (out_r & ~mask[N_OUT-1:0]) | wm[N_OUT-1:0];
      if (wr && ofs == OFS_RISE_EN) rise_en <= (rise_en & ~mask[N_IN-1:0]) | wm[N_IN-1:0];
      if (wr && ofs == OFS_FALL_EN) fall_en <= (fall_en & ~mask[N_IN-1:0]) | wm[N_IN-1:0];
      if (wr && ofs == OFS_IRQ_EN) irq_en <= (irq_en & ~mask[N_IN-1:0]) | wm[N_IN-1:0];
      // new captures are ORed after the clear so a same-cycle edge survives
      status <= (status & ~clr) | (rise & rise_en) | (fall & fall_en);
    end
endmodule

// File: tb/tb_iomem_gpio_bank.sv
// tb_iomem_gpio_bank: table-driven register checks plus edge-capture sequences against a read-data scoreboard
module tb_iomem_gpio_bank;
  import gpio_pkg::*;
  logic        clk = 0, resetn = 0, iomem_valid = 0, iomem_ready, irq;
  logic [3:0]  iomem_wstrb = 0;
  logic [31:0] iomem_addr = 0, iomem_wdata = 0, iomem_rdata;
  logic [15:0] gpio_in = 0, gpio_out;
  typedef struct {string nm; logic [31:0] exp;} sb_t;
  typedef struct {string nm; logic [3:0] ws; logic [4:0] ofs; logic [31:0] wd; logic [31:0] exp_rd; logic [15:0] exp_out;} vec_t;
  sb_t  sb[$];
  vec_t tbl[$];
  int total = 0, bad = 0, n_req = 0, n_ready = 0, k = 0;
  iomem_gpio_bank dut (
    .clk(clk), .resetn(resetn), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata), .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  always @(negedge clk)
    if (iomem_ready) begin
      sb_t e;
      n_ready++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: got rdata %h with no request pending", iomem_rdata);
      end else begin
        e = sb.pop_front();
        chk(e.nm, iomem_rdata, e.exp);
      end
    end
  task automatic bus(input string nm, input logic [3:0] ws, input logic [4:0] ofs, input logic [31:0] wd, input logic [31:0] exp);
    int n = 0;
    sb.push_back('{nm, exp});
    n_req++;
    @(negedge clk);
    iomem_valid = 1;
    iomem_wstrb = ws;
    iomem_addr  = {8'h03, 19'h0, ofs};
    iomem_wdata = wd;
    do begin @(negedge clk); n++; end while (!iomem_ready && n < 20);
    if (!iomem_ready) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no ready in %0d cycles want ready", nm, n);
      void'(sb.pop_back());
      n_req--;
    end
    iomem_valid = 0;
    iomem_wstrb = 0;
    @(negedge clk);
    chk({nm, "_ready_once"}, 32'(iomem_ready), 0);
  endtask
  initial begin
    for (int i = 0; i < 8; i++)
      tbl.push_back('{$sformatf("rst_rd%0d", i), 4'h0, 5'(i * 4), 32'h0, 32'h0, 16'h0});
    tbl.push_back('{"out_wr_b0",   4'b0001, OFS_OUT,     32'hFFFF_A5C3, 32'h0000_0000, 16'h00C3});
    tbl.push_back('{"out_wr_all",  4'b1111, OFS_OUT,     32'hFFFF_A5C3, 32'h0000_00C3, 16'hA5C3});
    tbl.push_back('{"out_rd",      4'b0000, OFS_OUT,     32'h0,         32'h0000_A5C3, 16'hA5C3});
    tbl.push_back('{"out_wr_b2",   4'b0100, OFS_OUT,     32'h1234_5678, 32'h0000_A5C3, 16'hA5C3});
    tbl.push_back('{"out_rd2",     4'b0000, OFS_OUT,     32'h0,         32'h0000_A5C3, 16'hA5C3});
    tbl.push_back('{"rise_wr",     4'b1111, OFS_RISE_EN, 32'h0000_0001, 32'h0,         16'hA5C3});
    tbl.push_back('{"rise_rd",     4'b0000, OFS_RISE_EN, 32'h0,         32'h0000_0001, 16'hA5C3});
    tbl.push_back('{"fall_wr_b1",  4'b0010, OFS_FALL_EN, 32'hFFFF_80FF, 32'h0,         16'hA5C3});
    tbl.push_back('{"fall_rd",     4'b0000, OFS_FALL_EN, 32'h0,         32'h0000_8000, 16'hA5C3});
    tbl.push_back('{"irqen_wr",    4'b1111, OFS_IRQ_EN,  32'h0000_0001, 32'h0,         16'hA5C3});
    tbl.push_back('{"irqen_rd",    4'b0000, OFS_IRQ_EN,  32'h0,         32'h0000_0001, 16'hA5C3});
    tbl.push_back('{"r18_wr",      4'b1111, 5'h18,       32'hFFFF_FFFF, 32'h0,         16'hA5C3});
    tbl.push_back('{"r18_rd",      4'b0000, 5'h18,       32'h0,         32'h0,         16'hA5C3});
    tbl.push_back('{"r1c_rd",      4'b0000, 5'h1C,       32'h0,         32'h0,         16'hA5C3});
    tbl.push_back('{"in_wr",       4'b1111, OFS_IN,      32'hFFFF_FFFF, 32'h0,         16'hA5C3});
    tbl.push_back('{"in_rd",       4'b0000, OFS_IN,      32'h0,         32'h0,         16'hA5C3});
    tbl.push_back('{"status_rd",   4'b0000, OFS_STATUS,  32'h0,         32'h0,         16'hA5C3});
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(iomem_ready), 0);
    chk("rst_rdata", iomem_rdata, 0);
    chk("rst_out", 32'(gpio_out), 0);
    chk("rst_irq", 32'(irq), 0);
    resetn = 1;
    foreach (tbl[i]) begin
      bus(tbl[i].nm, tbl[i].ws, tbl[i].ofs, tbl[i].wd, tbl[i].exp_rd);
      chk({tbl[i].nm, "_out"}, 32'(gpio_out), 32'(tbl[i].exp_out));
      chk({tbl[i].nm, "_irq"}, 32'(irq), 0);
    end
    gpio_in = 16'h0011;
    @(negedge clk); chk("irq_lat1", 32'(irq), 0);
    @(negedge clk); chk("irq_lat2", 32'(irq), 0);
    @(negedge clk); chk("irq_lat3", 32'(irq), 1);
    bus("in_0011", 4'h0, OFS_IN, 0, 32'h0000_0011);
    bus("status_rise0", 4'h0, OFS_STATUS, 0, 32'h0000_0001);
    gpio_in = 16'h0000;
    bus("in_lat_old", 4'h0, OFS_IN, 0, 32'h0000_0011);
    bus("in_lat_new", 4'h0, OFS_IN, 0, 32'h0);
    chk("irq_held", 32'(irq), 1);
    bus("status_clr", 4'hF, OFS_STATUS, 32'h1, 32'h0000_0001);
    chk("irq_cleared", 32'(irq), 0);
    bus("status_after_clr", 4'h0, OFS_STATUS, 0, 32'h0);
    gpio_in = 16'h0001;
    repeat (4) @(negedge clk);
    chk("irq_set", 32'(irq), 1);
    gpio_in = 16'h0000;
    repeat (4) @(negedge clk);
    gpio_in = 16'h0001;
    @(negedge clk);
    bus("clr_vs_rise", 4'hF, OFS_STATUS, 32'h1, 32'h0000_0001);
    chk("irq_set_wins", 32'(irq), 1);
    bus("status_set_wins", 4'h0, OFS_STATUS, 0, 32'h0000_0001);
    bus("status_clr2", 4'hF, OFS_STATUS, 32'h1, 32'h0000_0001);
    chk("irq_cleared2", 32'(irq), 0);
    gpio_in = 16'h8001;
    repeat (5) @(negedge clk);
    gpio_in = 16'h0001;
    repeat (5) @(negedge clk);
    bus("status_fall15", 4'h0, OFS_STATUS, 0, 32'h0000_8000);
    bus("status_clr_all", 4'hF, OFS_STATUS, 32'hFFFF_FFFF, 32'h0000_8000);
    @(posedge clk);
    #2 gpio_in = 16'h8001;
    #3 gpio_in = 16'h0001;
    repeat (5) @(negedge clk);
    bus("status_glitch", 4'h0, OFS_STATUS, 0, 32'h0);
    gpio_in = 16'h0003;
    repeat (5) @(negedge clk);
    bus("rise_en_late", 4'hF, OFS_RISE_EN, 32'h3, 32'h0000_0001);
    bus("status_no_retro", 4'h0, OFS_STATUS, 0, 32'h0);
    gpio_in = 16'h0001;
    repeat (5) @(negedge clk);
    gpio_in = 16'h0003;
    repeat (5) @(negedge clk);
    bus("status_rise1", 4'h0, OFS_STATUS, 0, 32'h0000_0002);
    @(negedge clk);
    k = n_ready;
    iomem_valid = 1;
    iomem_wstrb = 4'hF;
    iomem_addr  = 32'h0200_0000;
    iomem_wdata = 32'h0;
    repeat (10) @(negedge clk);
    chk("foreign_ready", 32'(n_ready), 32'(k));
    iomem_valid = 0;
    iomem_wstrb = 0;
    chk("foreign_out", 32'(gpio_out), 32'h0000_A5C3);
    bus("foreign_out_rd", 4'h0, OFS_OUT, 0, 32'h0000_A5C3);
    k = n_ready;
    @(negedge clk);
    iomem_valid = 1;
    iomem_wstrb = 4'hF;
    iomem_addr  = 32'h0300_0000;
    iomem_wdata = 32'h0000_FFFF;
    #2 resetn = 0;
    @(negedge clk);
    chk("abort_ready", 32'(n_ready), 32'(k));
    chk("abort_out", 32'(gpio_out), 0);
    chk("abort_irq", 32'(irq), 0);
    iomem_valid = 0;
    iomem_wstrb = 0;
    resetn = 1;
    bus("abort_out_rd", 4'h0, OFS_OUT, 0, 32'h0);
    bus("abort_rise_rd", 4'h0, OFS_RISE_EN, 0, 32'h0);
    chk("ready_count", 32'(n_ready), 32'(n_req));
    chk("sb_left", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
